// File: rtl/branch_pkg.sv
// Shared encodings, BTB entry layout and counter helpers
// for the ID-stage branch predictor.
package branch_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    localparam logic [2:0] BT_BNE  = 3'b001;
    localparam logic [2:0] BT_BEQ  = 3'b010;
    localparam logic [2:0] BT_BLEZ = 3'b011;
    localparam logic [2:0] BT_BGTZ = 3'b100;
    localparam logic [2:0] BT_BLTZ = 3'b101;
    localparam logic [2:0] BT_BGEZ = 3'b110;

    // Tag field sized for the smallest legal BTB; unused high bits stay 0.
    localparam int TAG_MAX_W = 30;

    localparam logic [1:0] CTR_WEAK_T   = 2'b10;
    localparam logic [1:0] CTR_STRONG_T = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    typedef enum logic [1:0] {
        WR_TRAIN_T  = 2'b00,
        WR_TRAIN_NT = 2'b01,
        WR_JUMP     = 2'b10
    } wr_op_e;

    function automatic logic [1:0] ctr_sat(
        input logic [1:0] c,
        input logic       up
    );
        if (up) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/id_branch_predictor_if.sv
// Fetch lookup, ID resolution and statistics signals
// between the pipeline and the branch predictor.
interface id_branch_predictor_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [31:0]       if_pc;
    logic              if_pred_taken;
    logic [31:0]       if_pred_target;
    logic              id_valid;
    logic              id_stall;
    logic [31:0]       id_pc;
    logic              id_pred_taken;
    logic [31:0]       id_pred_target;
    logic [1:0]        pcsrc;
    logic [2:0]        branchtype;
    logic [DATA_W-1:0] readdata1;
    logic [DATA_W-1:0] readdata2;
    logic [31:0]       imm;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [CNT_W-1:0]  stat_branches;
    logic [CNT_W-1:0]  stat_mispredicts;

    modport master (
        output if_pc, id_valid, id_stall, id_pc,
        output id_pred_taken, id_pred_target,
        output pcsrc, branchtype,
        output readdata1, readdata2, imm,
        input  if_pred_taken, if_pred_target,
        input  redirect, redirect_pc,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, id_valid, id_stall, id_pc,
        input  id_pred_taken, id_pred_target,
        input  pcsrc, branchtype,
        input  readdata1, readdata2, imm,
        output if_pred_taken, if_pred_target,
        output redirect, redirect_pc,
        output stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/btb_store.sv
// Direct-mapped BTB storage: one combinational read port and
// one read-modify-write port that applies the training rules.
module btb_store
    import branch_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output btb_entry_t           rd_entry,
    input  logic                 wr_en,
    input  wr_op_e               wr_op,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_MAX_W-1:0] wr_tag,
    input  logic [31:0]          wr_target
);

    logic [DEPTH-1:0]     valid_q;
    logic [1:0]           ctr_q    [DEPTH];
    logic [TAG_MAX_W-1:0] tag_q    [DEPTH];
    logic [31:0]          target_q [DEPTH];

    btb_entry_t cur;
    btb_entry_t entry_d;
    logic       upd_d;
    logic       hit;

    always_comb begin
        rd_entry.valid  = valid_q[rd_idx];
        rd_entry.tag    = tag_q[rd_idx];
        rd_entry.target = target_q[rd_idx];
        rd_entry.ctr    = ctr_q[rd_idx];
    end

    always_comb begin
        cur.valid  = valid_q[wr_idx];
        cur.tag    = tag_q[wr_idx];
        cur.target = target_q[wr_idx];
        cur.ctr    = ctr_q[wr_idx];
        hit        = cur.valid && (cur.tag == wr_tag);
        entry_d    = cur;
        upd_d      = 1'b0;
        if (wr_en) begin
            unique case (wr_op)
                WR_JUMP: begin
                    upd_d   = 1'b1;
                    entry_d = '{1'b1, wr_tag, wr_target, CTR_STRONG_T};
                end
                WR_TRAIN_T: begin
                    upd_d = 1'b1;
                    if (hit) begin
                        entry_d.ctr    = ctr_sat(cur.ctr, 1'b1);
                        entry_d.target = wr_target;
                    end else begin
                        entry_d = '{1'b1, wr_tag, wr_target, CTR_WEAK_T};
                    end
                end
                WR_TRAIN_NT: begin
                    // A not-taken miss never allocates.
                    if (hit) begin
                        upd_d       = 1'b1;
                        entry_d.ctr = ctr_sat(cur.ctr, 1'b0);
                    end
                end
                default: begin
                    upd_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= 2'b00;
            end
        end else if (upd_d) begin
            valid_q[wr_idx] <= entry_d.valid;
            ctr_q[wr_idx]   <= entry_d.ctr;
        end
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_d) begin
            tag_q[wr_idx]    <= entry_d.tag;
            target_q[wr_idx] <= entry_d.target;
        end
    end

endmodule

// File: rtl/id_branch_predictor.sv
// IF-stage BTB prediction plus ID-stage branch/jump resolution,
// mispredict redirect, BTB training and saturating statistics.
module id_branch_predictor
    import branch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BTB_DEPTH = 64,
    parameter int IDX_W     = $clog2(BTB_DEPTH),
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst,
    id_branch_predictor_if.slave bus
);

    function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc);
        logic [31:0] sh;
        sh = pc >> (IDX_W + 2);
        return sh[TAG_MAX_W-1:0];
    endfunction

    btb_entry_t        rd_entry;
    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  id_idx;
    logic              pred_hit;

    logic              resolve;
    logic              br_cond;
    logic              taken;
    logic [31:0]       target;
    logic              mispredict;
    logic              wr_en;
    wr_op_e            wr_op;

    logic signed [DATA_W-1:0] rs1;

    logic [CNT_W-1:0]  stat_br_q;
    logic [CNT_W-1:0]  stat_br_d;
    logic [CNT_W-1:0]  stat_mis_q;
    logic [CNT_W-1:0]  stat_mis_d;

    assign if_idx = bus.if_pc[IDX_W+1:2];
    assign id_idx = bus.id_pc[IDX_W+1:2];
    assign rs1    = $signed(bus.readdata1);

    btb_store #(
        .DEPTH (BTB_DEPTH),
        .IDX_W (IDX_W)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst),
        .rd_idx    (if_idx),
        .rd_entry  (rd_entry),
        .wr_en     (wr_en),
        .wr_op     (wr_op),
        .wr_idx    (id_idx),
        .wr_tag    (tag_of(bus.id_pc)),
        .wr_target (target)
    );

    always_comb begin
        pred_hit = rst && rd_entry.valid
                 && (rd_entry.tag == tag_of(bus.if_pc))
                 && rd_entry.ctr[1];
        bus.if_pred_taken  = pred_hit;
        bus.if_pred_target = pred_hit ? rd_entry.target : 32'd0;
    end

    always_comb begin
        br_cond = 1'b0;
        unique case (1'b1)
            (bus.branchtype == BT_BNE):  br_cond = bus.readdata1 != bus.readdata2;
            (bus.branchtype == BT_BEQ):  br_cond = bus.readdata1 == bus.readdata2;
            (bus.branchtype == BT_BLEZ): br_cond = rs1 <= 0;
            (bus.branchtype == BT_BGTZ): br_cond = rs1 > 0;
            (bus.branchtype == BT_BLTZ): br_cond = rs1 < 0;
            (bus.branchtype == BT_BGEZ): br_cond = rs1 >= 0;
            default:                     br_cond = 1'b0;
        endcase
    end

    always_comb begin
        resolve = rst && bus.id_valid && !bus.id_stall
                && (bus.pcsrc != PCSRC_SEQ);
        taken   = 1'b0;
        target  = bus.imm;
        unique case (bus.pcsrc)
            PCSRC_BR: taken = br_cond;
            PCSRC_J:  taken = 1'b1;
            PCSRC_JR: begin
                taken  = 1'b1;
                target = 32'(bus.readdata1);
            end
            default:  taken = 1'b0;
        endcase
        mispredict = (taken != bus.id_pred_taken)
                   || (taken && (target != bus.id_pred_target));
        bus.redirect    = resolve && mispredict;
        bus.redirect_pc = 32'd0;
        if (resolve) begin
            bus.redirect_pc = taken ? target : bus.id_pc + 32'd4;
        end
    end

    // jr targets are data dependent, so they never enter the BTB.
    always_comb begin
        wr_en = resolve && (bus.pcsrc != PCSRC_JR);
        wr_op = WR_TRAIN_NT;
        if (bus.pcsrc == PCSRC_J) begin
            wr_op = WR_JUMP;
        end else if (taken) begin
            wr_op = WR_TRAIN_T;
        end
    end

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (resolve && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + CNT_W'(1);
        end
        if (bus.redirect && (stat_mis_q != '1)) begin
            stat_mis_d = stat_mis_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_id_branch_predictor.sv
// Random and directed checks of id_branch_predictor against
// an array-based BTB/statistics model; two stat widths.
module tb_id_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_branch_predictor_if #(.DATA_W(32), .CNT_W(16)) bus ();
    id_branch_predictor_if #(.DATA_W(32), .CNT_W(2))  bus2 ();

    assign bus2.if_pc          = bus.if_pc;
    assign bus2.id_valid       = bus.id_valid;
    assign bus2.id_stall       = bus.id_stall;
    assign bus2.id_pc          = bus.id_pc;
    assign bus2.id_pred_taken  = bus.id_pred_taken;
    assign bus2.id_pred_target = bus.id_pred_target;
    assign bus2.pcsrc          = bus.pcsrc;
    assign bus2.branchtype     = bus.branchtype;
    assign bus2.readdata1      = bus.readdata1;
    assign bus2.readdata2      = bus.readdata2;
    assign bus2.imm            = bus.imm;

    id_branch_predictor #(.DATA_W(32), .BTB_DEPTH(64), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    id_branch_predictor #(.DATA_W(32), .BTB_DEPTH(64), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    bit          mv   [64];
    int unsigned mtag [64];
    int unsigned mtgt [64];
    int unsigned mctr [64];
    int unsigned m_br, m_mis, m_br2, m_mis2;

    bit          e_resolve, e_taken, e_redirect, e_pt;
    int unsigned e_target, e_rpc, e_ptgt;

    int unsigned pool [8] = '{32'h40, 32'h44, 32'h140, 32'h80,
                              32'h1040, 32'h50, 32'h200, 32'hFFC};
    int unsigned imms [4] = '{32'h100, 32'h200, 32'h300, 32'h400};
    int unsigned ops  [5] = '{0, 1, 32'hFFFF_FFFF, 5, 32'h8000_0000};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 0;
        end
        m_br = 0; m_mis = 0; m_br2 = 0; m_mis2 = 0;
    endfunction

    function automatic bit m_predict(input int unsigned pc);
        int unsigned i;
        i = (pc / 4) % 64;
        return mv[i] && (mtag[i] == pc / 256) && (mctr[i] >= 2);
    endfunction

    task automatic eval();
        int a, b;
        int unsigned i;
        a = bus.readdata1;
        b = bus.readdata2;
        e_resolve = rst && bus.id_valid && !bus.id_stall && (bus.pcsrc != 0);
        e_taken = (bus.pcsrc != 0);
        if (bus.pcsrc == 1) begin
            case (bus.branchtype)
                3'd1: e_taken = (a != b);
                3'd2: e_taken = (a == b);
                3'd3: e_taken = (a <= 0);
                3'd4: e_taken = (a > 0);
                3'd5: e_taken = (a < 0);
                3'd6: e_taken = (a >= 0);
                default: e_taken = 0;
            endcase
        end
        e_target = (bus.pcsrc == 3) ? bus.readdata1 : bus.imm;
        e_redirect = e_resolve && ((e_taken != bus.id_pred_taken)
                   || (e_taken && e_target != bus.id_pred_target));
        e_rpc = e_taken ? e_target : bus.id_pc + 4;
        i = (bus.if_pc / 4) % 64;
        e_pt = rst && m_predict(bus.if_pc);
        e_ptgt = mtgt[i];
    endtask

    task automatic m_update();
        int unsigned i, t;
        bit hit;
        if (!rst) return;
        eval();
        if (!e_resolve) return;
        if (m_br < 65535) m_br++;
        if (m_br2 < 3) m_br2++;
        if (e_redirect) begin
            if (m_mis < 65535) m_mis++;
            if (m_mis2 < 3) m_mis2++;
        end
        i = (bus.id_pc / 4) % 64;
        t = bus.id_pc / 256;
        hit = mv[i] && mtag[i] == t;
        if (bus.pcsrc == 1) begin
            if (hit && e_taken) begin
                mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
                mtgt[i] = e_target;
            end else if (hit) begin
                mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
            end else if (e_taken) begin
                mv[i] = 1; mtag[i] = t; mtgt[i] = e_target; mctr[i] = 2;
            end
        end else if (bus.pcsrc == 2) begin
            mv[i] = 1; mtag[i] = t; mtgt[i] = e_target; mctr[i] = 3;
        end
    endtask

    always @(negedge clk) begin
        eval();
        chk("redirect", 64'(bus.redirect), 64'(e_redirect));
        chk("redirect2", 64'(bus2.redirect), 64'(e_redirect));
        if (e_redirect || !rst)
            chk("redirect_pc", 64'(bus.redirect_pc), rst ? 64'(e_rpc) : 64'd0);
        chk("pred_taken", 64'(bus.if_pred_taken), 64'(e_pt));
        if (e_pt)
            chk("pred_target", 64'(bus.if_pred_target), 64'(e_ptgt));
        else if (!rst)
            chk("pred_target_rst", 64'(bus.if_pred_target), 64'd0);
        chk("stat_branches", 64'(bus.stat_branches), 64'(m_br));
        chk("stat_mispredicts", 64'(bus.stat_mispredicts), 64'(m_mis));
        chk("stat_branches2", 64'(bus2.stat_branches), 64'(m_br2));
        chk("stat_mispredicts2", 64'(bus2.stat_mispredicts), 64'(m_mis2));
    end

    task automatic cyc();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] ipc);
        bus.if_pc = ipc;
        bus.id_valid = 0; bus.id_stall = 0; bus.id_pc = 0;
        bus.id_pred_taken = 0; bus.id_pred_target = 0;
        bus.pcsrc = 0; bus.branchtype = 0;
        bus.readdata1 = 0; bus.readdata2 = 0; bus.imm = 0;
    endtask

    task automatic go(input logic [31:0] pc, input logic [1:0] ps,
                      input logic [2:0] bt, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] im,
                      input logic pt, input logic [31:0] ptg);
        bus.id_valid = 1; bus.id_stall = 0; bus.id_pc = pc;
        bus.pcsrc = ps; bus.branchtype = bt;
        bus.readdata1 = r1; bus.readdata2 = r2; bus.imm = im;
        bus.id_pred_taken = pt; bus.id_pred_target = ptg;
    endtask

    task automatic do_reset();
        rst = 0;
        m_clear();
        cyc();
        cyc();
        rst = 1;
    endtask

    initial begin
        int unsigned p;
        m_clear();
        idle(32'h40);
        settle();
        chk("rst_redirect", 64'(bus.redirect), 64'd0);
        chk("rst_rpc", 64'(bus.redirect_pc), 64'd0);
        do_reset();

        go(32'h40, 2'b01, 3'b001, 5, 7, 32'h100, 0, 0);
        settle();
        chk("bne_redirect", 64'(bus.redirect), 64'd1);
        chk("bne_rpc", 64'(bus.redirect_pc), 64'h100);
        cyc();
        idle(32'h40);
        settle();
        chk("bne_pred", 64'(bus.if_pred_taken), 64'd1);
        chk("bne_ptgt", 64'(bus.if_pred_target), 64'h100);
        cyc();

        go(32'h40, 2'b01, 3'b001, 5, 5, 32'h100, 1, 32'h100);
        settle();
        chk("bnent_redirect", 64'(bus.redirect), 64'd1);
        chk("bnent_rpc", 64'(bus.redirect_pc), 64'h44);
        cyc();
        idle(32'h40);
        settle();
        chk("bnent_pred", 64'(bus.if_pred_taken), 64'd0);
        cyc();

        go(32'h50, 2'b01, 3'b101, 32'hFFFF_FFFF, 0, 32'h300, 0, 0);
        settle();
        chk("bltz_rpc", 64'(bus.redirect_pc), 64'h300);
        cyc();
        go(32'h54, 2'b01, 3'b110, 32'hFFFF_FFFF, 0, 32'h300, 0, 0);
        settle();
        chk("bgez_redirect", 64'(bus.redirect), 64'd0);
        cyc();
        go(32'h58, 2'b01, 3'b011, 0, 0, 32'h304, 0, 0);
        settle();
        chk("blez_rpc", 64'(bus.redirect_pc), 64'h304);
        cyc();

        for (int k = 0; k < 3; k++) begin
            go(32'h80, 2'b11, 3'b000, 32'h200, 0, 32'hDEAD, 0, 0);
            settle();
            chk("jr_redirect", 64'(bus.redirect), 64'd1);
            chk("jr_rpc", 64'(bus.redirect_pc), 64'h200);
            cyc();
        end
        idle(32'h80);
        settle();
        chk("jr_no_entry", 64'(bus.if_pred_taken), 64'd0);
        cyc();

        go(32'h90, 2'b01, 3'b010, 3, 3, 32'h400, 0, 0);
        bus.id_stall = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("stall_redirect", 64'(bus.redirect), 64'd0);
            chk("stall_br", 64'(bus.stat_branches), 64'd8);
            cyc();
        end
        bus.id_stall = 0;
        settle();
        chk("unstall_rpc", 64'(bus.redirect_pc), 64'h400);
        cyc();
        idle(32'h40);
        settle();
        chk("stat_br_lit", 64'(bus.stat_branches), 64'd9);
        chk("stat_mis_lit", 64'(bus.stat_mispredicts), 64'd8);
        chk("stat_mis2_sat", 64'(bus2.stat_mispredicts), 64'd3);

        do_reset();
        settle();
        chk("post_rst_mis2", 64'(bus2.stat_mispredicts), 64'd0);
        chk("post_rst_pred", 64'(bus.if_pred_taken), 64'd0);
        cyc();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 200 == 0) begin
                rst = 0;
                m_clear();
                cyc();
                rst = 1;
            end
            bus.if_pc = pool[$urandom % 8];
            bus.id_valid = ($urandom % 4) != 0;
            bus.id_stall = ($urandom % 5) == 0;
            p = pool[$urandom % 8];
            bus.id_pc = p;
            bus.pcsrc = 2'($urandom % 4);
            bus.branchtype = 3'($urandom % 8);
            bus.readdata1 = ($urandom % 6 == 0) ? $urandom : ops[$urandom % 5];
            bus.readdata2 = ($urandom % 6 == 0) ? $urandom : ops[$urandom % 5];
            bus.imm = imms[$urandom % 4];
            if ($urandom % 2) begin
                bus.id_pred_taken = m_predict(p);
                bus.id_pred_target = mtgt[(p / 4) % 64];
            end else begin
                bus.id_pred_taken = 1'($urandom % 2);
                bus.id_pred_target = imms[$urandom % 4];
            end
            cyc();
        end

        idle(32'h40);
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
